// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Sequences a PLL out of reset, waits for a stable lock and only then
//   releases the downstream reset. Lock timeouts trigger a bounded number of
//   PLL reset retries before the block parks in FAIL until retry_req.
//
//   Optional feature macro: PLL_SUP_LOSS_CNT_EN
//     defined   -> loss_cnt counts RUN->RESET_PLL transitions (saturates at 255)
//     undefined -> loss_cnt tied to 0
//
// Ports
//   refclk    in   PLL reference clock (sole clock)
//   rst       in   asynchronous active-high reset
//   locked    in   PLL lock indicator, asynchronous to refclk
//   retry_req in   level, restarts sequencing from FAIL
//   pll_rst   out  registered reset to the PLL
//   sys_rst   out  registered downstream reset, low only in RUN
//   ready     out  high only in RUN
//   fail      out  high only in FAIL
//   state     out  current state (RESET_PLL=0 WAIT_LOCK=1 STABLE=2 RUN=3 FAIL=4)
//   loss_cnt  out  saturating count of lock losses seen in RUN
module pll_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 1000,
    parameter int unsigned STABLE_CYCLES  = 256,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       retry_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [2:0] state,
    output logic [7:0] loss_cnt
);

    localparam int unsigned CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned RETRY_W   = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t             cur_q;
    state_t             nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_d;
    logic [1:0]         sync_q;
    logic               lock_s;

    logic pll_rst_q;
    logic sys_rst_q;
    logic ready_q;
    logic fail_q;

    // Two-flop synchronizer for the asynchronous lock indicator
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], locked};
        end
    end

    assign lock_s = sync_q[1];

    // State, counters and registered outputs
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cur_q     <= S_RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            cur_q     <= nxt;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= (nxt == S_RESET_PLL) || (nxt == S_FAIL);
            sys_rst_q <= (nxt != S_RUN);
            ready_q   <= (nxt == S_RUN);
            fail_q    <= (nxt == S_FAIL);
        end
    end

    // Next-state, retry and cycle-counter logic
    always_comb begin
        nxt     = cur_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;

        case (cur_q)
            S_RESET_PLL: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                    nxt = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // A lock seen on the timeout cycle wins over the timeout
                if (lock_s) begin
                    nxt = S_STABLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_q + RETRY_W'(1);
                    nxt     = (retry_d == RETRY_W'(MAX_RETRIES)) ? S_FAIL : S_RESET_PLL;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    nxt = S_WAIT_LOCK;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    nxt = S_RESET_PLL;
                end
            end
            S_FAIL: begin
                if (retry_req) begin
                    nxt     = S_RESET_PLL;
                    retry_d = '0;
                end
            end
            default: begin
                nxt = S_RESET_PLL;
            end
        endcase

        // Retry budget is restored once a lock has been fully qualified
        if (nxt == S_RUN) begin
            retry_d = '0;
        end

        // Counter restarts on every state entry; saturates instead of wrapping
        if (nxt != cur_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef PLL_SUP_LOSS_CNT_EN
    logic [7:0] loss_q;
    logic       lost_lock_c;

    assign lost_lock_c = (cur_q == S_RUN) && !lock_s;

    // Saturating lock-loss counter, cleared only by rst
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_q <= 8'd0;
        end else if (lost_lock_c && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = 8'd0;
`endif

    assign pll_rst = pll_rst_q;
    assign sys_rst = sys_rst_q;
    assign ready   = ready_q;
    assign fail    = fail_q;
    assign state   = cur_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: the stimulus pushes one expected
// record per state transition (dwell in the previous state, new state and
// outputs); a monitor pops and compares on each observed state change.
module tb_pll_lock_supervisor;

    localparam int unsigned PLL_RST_CYCLES = 4;
    localparam int unsigned LOCK_TIMEOUT   = 20;
    localparam int unsigned STABLE_CYCLES  = 8;
    localparam int unsigned MAX_RETRIES    = 2;

    logic       refclk    = 1'b0;
    logic       rst       = 1'b1;
    logic       locked    = 1'b0;
    logic       retry_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    logic [7:0] loss_cnt;

    typedef struct packed {
        logic [15:0] dwell;
        logic [2:0]  st;
        logic        pll_rst;
        logic        sys_rst;
        logic        ready;
        logic        fail;
        logic [7:0]  loss;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   exp_loss = 0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .locked   (locked),
        .retry_req(retry_req),
        .pll_rst  (pll_rst),
        .sys_rst  (sys_rst),
        .ready    (ready),
        .fail     (fail),
        .state    (state),
        .loss_cnt (loss_cnt)
    );

    always #5 refclk = ~refclk;

    // Advance n falling edges, then step just past the edge to drive inputs
    task automatic step(input int n);
        repeat (n) @(negedge refclk);
        #1;
    endtask

    // Expected outputs for a state entry
    task automatic push(input int dwell, input logic [2:0] st);
        exp_t e;
        e.dwell   = 16'(dwell);
        e.st      = st;
        e.pll_rst = (st == 3'd0) || (st == 3'd4);
        e.sys_rst = (st != 3'd3);
        e.ready   = (st == 3'd3);
        e.fail    = (st == 3'd4);
        e.loss    = 8'(exp_loss);
        exp_q.push_back(e);
    endtask

    task automatic bump_loss();
`ifdef PLL_SUP_LOSS_CNT_EN
        if (exp_loss < 255) exp_loss++;
`endif
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare on every state change
    initial begin : monitor
        logic [2:0]  prev;
        int unsigned dwell;
        exp_t        e;
        exp_t        a;
        prev  = 3'd0;
        dwell = 1;
        forever begin
            @(negedge refclk);
            if (rst) begin
                prev  = 3'd0;
                dwell = 1;
            end else if (state != prev) begin
                a = '{dwell: 16'(dwell), st: state, pll_rst: pll_rst, sys_rst: sys_rst,
                      ready: ready, fail: fail, loss: loss_cnt};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_transition: got state %0d after %0d cycles (t=%0t)",
                             state, dwell, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        n_err++;
                        $display("FAIL transition: got dwell=%0d st=%0d pll=%b sys=%b rdy=%b fail=%b loss=%0d expected dwell=%0d st=%0d pll=%b sys=%b rdy=%b fail=%b loss=%0d (t=%0t)",
                                 a.dwell, a.st, a.pll_rst, a.sys_rst, a.ready, a.fail, a.loss,
                                 e.dwell, e.st, e.pll_rst, e.sys_rst, e.ready, e.fail, e.loss, $time);
                    end
                end
                prev  = state;
                dwell = 1;
            end else begin
                dwell++;
            end
        end
    end

    initial begin : stimulus
        int n_loops;

        // Reset values
        step(2);
        chk("rst_state",   8'(state),   8'd0);
        chk("rst_pll_rst", 8'(pll_rst), 8'd1);
        chk("rst_sys_rst", 8'(sys_rst), 8'd1);
        chk("rst_ready",   8'(ready),   8'd0);
        chk("rst_fail",    8'(fail),    8'd0);
        chk("rst_loss",    loss_cnt,    8'd0);

        push(4, 3'd1);
        rst = 1'b0;
        step(4);                            // first cycle of WAIT_LOCK

        // Normal lock: locked rises on the 5th WAIT_LOCK cycle
        step(4);
        push(7, 3'd2);
        push(8, 3'd3);
        locked = 1'b1;
        step(11);                           // first cycle of RUN

        // Lock loss in RUN, then relock
        step(4);
        bump_loss();
        push(7, 3'd0);
        push(4, 3'd1);
        locked = 1'b0;
        step(7);                            // first cycle of WAIT_LOCK
        step(2);
        push(5, 3'd2);
        locked = 1'b1;
        step(7);                            // 5th cycle of STABLE

        // Glitch in STABLE: 3 cycles low
        push(7, 3'd1);
        locked = 1'b0;
        step(3);
        push(3, 3'd2);
        push(8, 3'd3);
        locked = 1'b1;
        step(11);                           // first cycle of RUN

        // Timeouts to FAIL; retry_req toggled where it must be ignored
        step(2);
        bump_loss();
        push(5, 3'd0);
        push(4, 3'd1);
        push(20, 3'd0);
        push(4, 3'd1);
        push(20, 3'd4);
        locked = 1'b0;
        step(5);
        retry_req = 1'b1;
        step(40);
        retry_req = 1'b0;
        step(11);                           // 6th cycle of FAIL
        chk("fail_held", 8'(fail), 8'd1);
        push(6, 3'd0);
        push(4, 3'd1);
        retry_req = 1'b1;
        step(1);
        retry_req = 1'b0;

        // Lock first seen on the timeout cycle: STABLE wins
        step(21);
        push(20, 3'd2);
        push(8, 3'd3);
        locked = 1'b1;
        step(11);                           // first cycle of RUN

        // Asynchronous reset between edges while in RUN
        step(2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state",   8'(state),   8'd0);
        chk("arst_pll_rst", 8'(pll_rst), 8'd1);
        chk("arst_sys_rst", 8'(sys_rst), 8'd1);
        chk("arst_ready",   8'(ready),   8'd0);
        chk("arst_fail",    8'(fail),    8'd0);
        chk("arst_loss",    loss_cnt,    8'd0);
        exp_loss = 0;
        step(2);
        push(4, 3'd1);
        push(1, 3'd2);
        push(8, 3'd3);
        rst = 1'b0;
        step(14);                           // 2nd cycle of RUN

        // Repeated lock losses (saturation when the counter is enabled)
`ifdef PLL_SUP_LOSS_CNT_EN
        n_loops = 300;
`else
        n_loops = 4;
`endif
        for (int i = 0; i < n_loops; i++) begin
            bump_loss();
            push(4, 3'd0);
            push(4, 3'd1);
            push(1, 3'd2);
            push(8, 3'd3);
            locked = 1'b0;
            step(3);
            locked = 1'b1;
            step(14);
        end

        step(5);
        chk("final_loss", loss_cnt, 8'(exp_loss));
        chk("final_ready", 8'(ready), 8'd1);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_transitions: got %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
